// File: rtl/dcache_sram_macro.sv
// rtl/dcache_sram_macro.sv - single-port byte-enabled synchronous SRAM model for the L1 dcache data/tag arrays
// Array is never reset; only the registered read port is cleared by rst_ni or test_rst_i.
module dcache_sram_macro #(
   parameter  int DATA_WIDTH = 64,
   parameter  int NUM_WORDS  = 1024,
   localparam int ADDR_W     = $clog2(NUM_WORDS),
   localparam int BE_W       = (DATA_WIDTH + 7) / 8
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  test_rst_i,
   input  logic                  req_i,
   input  logic                  we_i,
   input  logic [ADDR_W-1:0]     addr_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   input  logic [BE_W-1:0]       be_i,
   output logic [DATA_WIDTH-1:0] rdata_o
);

   logic [DATA_WIDTH-1:0] mem [NUM_WORDS];
   logic [DATA_WIDTH-1:0] bit_mask;
   logic                  in_range;
   logic                  do_write;
   logic                  do_read;

   // The top lane may be narrower than a byte when DATA_WIDTH is not a multiple of 8.
   for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_mask
      assign bit_mask[i] = be_i[i/8];
   end

   assign in_range = ({1'b0, addr_i} < (ADDR_W+1)'(NUM_WORDS));
   assign do_write = req_i & we_i & ~test_rst_i & in_range;
   assign do_read  = req_i & ~we_i;

   always_ff @(posedge clk_i) begin
      if (rst_ni && do_write) begin
         mem[addr_i] <= (mem[addr_i] & ~bit_mask) | (wdata_i & bit_mask);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rdata_o <= '0;
      end else if (test_rst_i) begin
         rdata_o <= '0;
      end else if (do_read) begin
         rdata_o <= in_range ? mem[addr_i] : '0;
      end
   end

endmodule

// File: tb/tb_dcache_sram_macro.sv
// tb/tb_dcache_sram_macro.sv - randomized bench for dcache_sram_macro against a lane-level memory model
// Instance 0 is a 64-bit x 16 data array, instance 1 a 44-bit x 12 tag-style array with out-of-range addresses.
module tb_dcache_sram_macro;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        test_rst;
   logic        req  [2];
   logic        we   [2];
   logic [3:0]  addr [2];
   logic [63:0] wd   [2];
   logic [7:0]  be   [2];
   logic [63:0] rd64;
   logic [43:0] rd44;

   logic [63:0] mm     [2][16];
   logic [63:0] km     [2][16];
   logic [63:0] exp_rd [2];
   logic [63:0] exp_kn [2];

   int vectors     = 0;
   int miscompares = 0;
   bit chk_en      = 1'b0;

   always #5 clk = ~clk;

   dcache_sram_macro #(.DATA_WIDTH(64), .NUM_WORDS(16)) u_dut64 (
      .clk_i(clk), .rst_ni(rst_n), .test_rst_i(test_rst),
      .req_i(req[0]), .we_i(we[0]), .addr_i(addr[0]),
      .wdata_i(wd[0]), .be_i(be[0]), .rdata_o(rd64)
   );

   dcache_sram_macro #(.DATA_WIDTH(44), .NUM_WORDS(12)) u_dut44 (
      .clk_i(clk), .rst_ni(rst_n), .test_rst_i(test_rst),
      .req_i(req[1]), .we_i(we[1]), .addr_i(addr[1]),
      .wdata_i(wd[1][43:0]), .be_i(be[1][5:0]), .rdata_o(rd44)
   );

   function automatic logic [63:0] dut_rd(input int i);
      return (i == 0) ? rd64 : {20'h0, rd44};
   endfunction

   function automatic int depth(input int i);
      return (i == 0) ? 16 : 12;
   endfunction

   function automatic int lanes(input int i);
      return (i == 0) ? 8 : 6;
   endfunction

   function automatic logic [63:0] wmask(input int i);
      return (i == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0FFF_FFFF_FFFF;
   endfunction

   task automatic clear_outputs();
      for (int i = 0; i < 2; i++) begin
         exp_rd[i] = 64'h0;
         exp_kn[i] = 64'hFFFF_FFFF_FFFF_FFFF;
      end
   endtask

   // What one rising edge must do to each array and its read register.
   task automatic model_edge();
      logic [63:0] bm;
      for (int i = 0; i < 2; i++) begin
         if (!rst_n || test_rst) begin
            exp_rd[i] = 64'h0;
            exp_kn[i] = 64'hFFFF_FFFF_FFFF_FFFF;
         end else if (req[i]) begin
            if (we[i]) begin
               if (int'(addr[i]) < depth(i)) begin
                  bm = 64'h0;
                  for (int k = 0; k < lanes(i); k++)
                     if (((be[i] >> k) & 8'd1) != 8'd0) bm = bm | (64'hFF << (8 * k));
                  bm = bm & wmask(i);
                  mm[i][addr[i]] = (mm[i][addr[i]] & ~bm) | (wd[i] & bm);
                  km[i][addr[i]] = km[i][addr[i]] | bm;
               end
            end else if (int'(addr[i]) < depth(i)) begin
               exp_rd[i] = mm[i][addr[i]];
               exp_kn[i] = km[i][addr[i]];
            end else begin
               exp_rd[i] = 64'h0;
               exp_kn[i] = 64'hFFFF_FFFF_FFFF_FFFF;
            end
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic idle();
      for (int i = 0; i < 2; i++) begin
         req[i] = 1'b0; we[i] = 1'b0; addr[i] = 4'h0; wd[i] = 64'h0; be[i] = 8'h0;
      end
   endtask

   task automatic drive(input int i, input logic r, input logic w, input logic [3:0] a,
                        input logic [63:0] d, input logic [7:0] b);
      req[i] = r; we[i] = w; addr[i] = a; wd[i] = d; be[i] = b;
   endtask

   task automatic lit(input string name, input int i, input logic [63:0] v);
      vectors++;
      if (dut_rd(i) !== v || exp_rd[i] !== v) begin
         miscompares++;
         $display("FAIL %s: actual=%h model=%h required=%h", name, dut_rd(i), exp_rd[i], v);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         for (int i = 0; i < 2; i++) begin
            vectors++;
            if (((dut_rd(i) ^ exp_rd[i]) & exp_kn[i]) !== 64'h0) begin
               miscompares++;
               $display("FAIL rdata[%0d] t=%0t: actual=%h required=%h checked_bits=%h",
                        i, $time, dut_rd(i), exp_rd[i], exp_kn[i]);
            end
         end
      end
   end

   initial begin
      rst_n = 1'b0;
      test_rst = 1'b0;
      idle();
      for (int i = 0; i < 2; i++)
         for (int a = 0; a < 16; a++) begin
            mm[i][a] = 64'h0;
            km[i][a] = 64'h0;
         end
      clear_outputs();
      repeat (3) step();
      rst_n = 1'b1;
      chk_en = 1'b1;
      step();
      lit("reset_64", 0, 64'h0);
      lit("reset_44", 1, 64'h0);

      drive(0, 1, 1, 4'd5, 64'h0123_4567_89AB_CDEF, 8'hFF); step();
      drive(0, 1, 0, 4'd5, 64'h0, 8'h0); step();
      lit("full_word", 0, 64'h0123_4567_89AB_CDEF);

      drive(0, 1, 1, 4'd5, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F); step();
      drive(0, 1, 0, 4'd5, 64'h0, 8'h0); step();
      lit("partial_be", 0, 64'h0123_4567_FFFF_FFFF);

      idle();
      drive(1, 1, 1, 4'd3, 64'h0, 8'h3F); step();
      drive(1, 1, 1, 4'd3, 64'h0ABC_DEF0_1234, 8'h20); step();
      drive(1, 1, 0, 4'd3, 64'h0, 8'h0); step();
      lit("w44_lane5", 1, 64'h0A00_0000_0000);

      idle();
      drive(0, 1, 0, 4'd5, 64'h0, 8'h0); step();
      drive(0, 1, 1, 4'd5, 64'h1111_2222_3333_4444, 8'hFF); step();
      lit("no_write_through", 0, 64'h0123_4567_FFFF_FFFF);
      idle();
      for (int n = 0; n < 3; n++) begin
         step();
         lit("idle_hold", 0, 64'h0123_4567_FFFF_FFFF);
      end
      drive(0, 1, 0, 4'd5, 64'h0, 8'h0); step();
      lit("read_after_hold", 0, 64'h1111_2222_3333_4444);

      drive(0, 1, 1, 4'd7, 64'hAAAA_AAAA_AAAA_AAAA, 8'hFF); step();
      drive(0, 1, 0, 4'd7, 64'h0, 8'h0); step();
      lit("pre_test_reset", 0, 64'hAAAA_AAAA_AAAA_AAAA);
      test_rst = 1'b1;
      drive(0, 1, 1, 4'd7, 64'h55, 8'hFF); step();
      lit("test_reset_zero", 0, 64'h0);
      test_rst = 1'b0;
      drive(0, 1, 0, 4'd7, 64'h0, 8'h0); step();
      lit("test_reset_no_write", 0, 64'hAAAA_AAAA_AAAA_AAAA);

      idle();
      drive(1, 1, 1, 4'd2, 64'h0FFF_FFFF_FFFF, 8'h3F); step();
      drive(1, 1, 0, 4'd2, 64'h0, 8'h0); step();
      lit("oor_pre", 1, 64'h0FFF_FFFF_FFFF);
      drive(1, 1, 0, 4'd13, 64'h0, 8'h0); step();
      lit("oor_read_zero", 1, 64'h0);

      drive(1, 1, 0, 4'd2, 64'h0, 8'h0); step();
      lit("pre_async_rst", 1, 64'h0FFF_FFFF_FFFF);
      drive(0, 1, 1, 4'd7, 64'h0, 8'hFF);
      rst_n = 1'b0;
      clear_outputs();
      #2;
      lit("async_rst_44", 1, 64'h0);
      step();
      rst_n = 1'b1;
      idle();
      drive(0, 1, 0, 4'd7, 64'h0, 8'h0); step();
      lit("write_lost_in_reset", 0, 64'hAAAA_AAAA_AAAA_AAAA);

      for (int n = 0; n < 3000; n++) begin
         for (int i = 0; i < 2; i++) begin
            req[i]  = ($urandom_range(0, 3) != 0);
            we[i]   = $urandom_range(0, 1) != 0;
            addr[i] = 4'($urandom_range(0, 15));
            wd[i]   = {$urandom, $urandom};
            be[i]   = 8'($urandom);
         end
         test_rst = ($urandom_range(0, 31) == 0);
         step();
      end
      test_rst = 1'b0;
      idle();
      step();
      chk_en = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
